// File: rtl/tinymips_mem_ctrl.sv
// Memory-side responder for the TinyMIPS RAM bus: word RAM below IO_BASE, I/O registers above,
// plus a program-load port that fills RAM while the core is held in reset.
module tinymips_mem_ctrl #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_toRAM,
  input  logic [DATA_W-1:0] data_toRAM,
  input  logic              wrEn,
  output logic [DATA_W-1:0] data_fromRAM,
  output logic              cpu_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN, S_HALT} state_t;

  localparam int                DEPTH       = int'(IO_BASE);
  localparam logic [ADDR_W-1:0] IO_GPIO_OUT = IO_BASE;
  localparam logic [ADDR_W-1:0] IO_GPIO_IN  = IO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IO_CYC      = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IO_CTRL     = IO_BASE + ADDR_W'(3);

  state_t            st, st_nxt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] cyc;
  logic [DATA_W-1:0] rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ld_fire;
  logic              halt_wr;

  // Load handshake: a beat transfers on a rising edge where ld_valid && ld_ready; ld_ready is
  // high only in LOAD and never depends on ld_valid, so the loader may hold a beat indefinitely.
  assign ld_ready  = (st == S_LOAD);
  assign cpu_rst   = (st != S_RUN);
  assign halted    = (st == S_HALT);
  assign dbg_state = st;
  assign ld_fire   = ld_valid && ld_ready;
  assign halt_wr   = (st == S_RUN) && wrEn && (addr_toRAM == IO_CTRL) && (data_toRAM == '1);

  always_comb begin
    st_nxt = st;
    case (st)
      S_LOAD:    if (ld_fire && ld_last) st_nxt = S_RELEASE;
      S_RELEASE: st_nxt = S_RUN;
      S_RUN:     if (halt_wr) st_nxt = S_HALT;
      S_HALT:    if (ld_valid) st_nxt = S_LOAD;
      default:   st_nxt = S_LOAD;
    endcase
  end

  // Unknown or unmapped addresses fall through to the zero default.
  always_comb begin
    rdata = '0;
    if (addr_toRAM < IO_BASE) begin
      rdata = mem[addr_toRAM];
    end else begin
      case (addr_toRAM)
        IO_GPIO_OUT: rdata = gpio_out;
        IO_GPIO_IN:  rdata = gpio_in;
        IO_CYC:      rdata = cyc;
        IO_CTRL:     rdata = {{(DATA_W-1){1'b0}}, (st == S_RUN)};
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_toRAM;
    ram_wdata = data_toRAM;
    if (rst && ld_fire && (ld_addr < IO_BASE)) begin
      ram_we    = 1'b1;
      ram_waddr = ld_addr;
      ram_wdata = ld_data;
    end else if (rst && (st == S_RUN) && wrEn && (addr_toRAM < IO_BASE)) begin
      ram_we = 1'b1;
    end
  end

  // RAM contents deliberately survive reset so a partial image is kept.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= S_LOAD;
      data_fromRAM <= '0;
      gpio_out     <= '0;
      cyc          <= '0;
    end else begin
      st <= st_nxt;
      if (st == S_RUN) begin
        data_fromRAM <= rdata;
        cyc          <= cyc + DATA_W'(1);
        if (wrEn && (addr_toRAM == IO_GPIO_OUT)) gpio_out <= data_toRAM;
      end
      if ((st == S_HALT) && ld_valid) cyc <= '0;
    end
  end

endmodule
